// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB machine timer: register map, ctrl fields,
// APB slave states and the per-register load strobes into the timer core.
package apb_timer_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned STB_W  = REG_W / 8;
  localparam int unsigned OFFS_W = 3;
  localparam int unsigned TIME_W = 64;

  localparam logic [OFFS_W-1:0] OFF_MTIME_LO = 3'd0;
  localparam logic [OFFS_W-1:0] OFF_MTIME_HI = 3'd1;
  localparam logic [OFFS_W-1:0] OFF_CMP_LO   = 3'd2;
  localparam logic [OFFS_W-1:0] OFF_CMP_HI   = 3'd3;
  localparam logic [OFFS_W-1:0] OFF_CTRL     = 3'd4;
  localparam logic [OFFS_W-1:0] OFF_STATUS   = 3'd5;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IE_BIT     = 1;
  localparam int unsigned CTRL_DIV_LSB    = 8;
  localparam int unsigned STATUS_PEND_BIT = 0;

  localparam logic [TIME_W-1:0] MTIMECMP_RST = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [REG_W-1:0] data;
    logic [STB_W-1:0] stb;
  } wr_req_t;

  typedef struct packed {
    logic mtime_lo;
    logic mtime_hi;
    logic cmp_lo;
    logic cmp_hi;
    logic ctrl;
    logic clr_pend;
  } reg_ld_t;

  // Byte-strobed merge of a write into an existing 32-bit register value.
  function automatic logic [REG_W-1:0] apply_strobe(input logic [REG_W-1:0] old_val,
                                                    input logic [REG_W-1:0] new_val,
                                                    input logic [STB_W-1:0] stb);
    logic [REG_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(STB_W); i++) begin
      if (stb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle between the CPU-side master and the timer slave.
interface apb_timer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   APB_paddr;
  logic [DATA_WIDTH-1:0]   APB_pdata;
  logic [DATA_WIDTH-1:0]   APB_prdata;
  logic                    APB_psel;
  logic                    APB_penable;
  logic                    APB_pwrite;
  logic [DATA_WIDTH/8-1:0] APB_pstb;
  logic                    APB_pready;
  logic                    APB_perr;

  modport master (
    output APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    input  APB_prdata, APB_pready, APB_perr
  );

  modport slave (
    input  APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    output APB_prdata, APB_pready, APB_perr
  );
endinterface

// File: rtl/apb_timer_core.sv
// Timer datapath: prescaler, 64-bit mtime, mtimecmp, sticky pending and irq.
// Register writes arrive as one-cycle load strobes with a shared byte-strobed payload.
module timer_core
  import apb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rts_n,
  input  reg_ld_t           ld,
  input  wr_req_t           wr,
  output logic [TIME_W-1:0] mtime,
  output logic [TIME_W-1:0] mtimecmp,
  output logic [REG_W-1:0]  ctrl_c,
  output logic              pending,
  output logic              irq
);

  logic [TIME_W-1:0]         mtime_q, mtime_d;
  logic [TIME_W-1:0]         cmp_q, cmp_d;
  logic [PRESCALE_WIDTH-1:0] div_q, div_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      en_q, en_d;
  logic                      ie_q, ie_d;
  logic                      pending_q, pending_d;
  logic                      irq_q, irq_d;

  always_comb begin
    mtime_d   = mtime_q;
    cmp_d     = cmp_q;
    div_d     = div_q;
    presc_d   = presc_q;
    en_d      = en_q;
    ie_d      = ie_q;
    irq_d     = pending_q & ie_q;
    // Compare sets, software clear only takes effect when the compare is false.
    pending_d = (mtime_q >= cmp_q) || (pending_q && !ld.clr_pend);

    if (en_q) begin
      if (presc_q >= div_q) begin
        presc_d = '0;
        mtime_d = mtime_q + TIME_W'(1);
      end else begin
        presc_d = presc_q + PRESCALE_WIDTH'(1);
      end
    end

    // A software write to mtime overrides (drops) a coincident increment.
    if (ld.mtime_lo) mtime_d = {mtime_q[TIME_W-1:REG_W], apply_strobe(mtime_q[REG_W-1:0], wr.data, wr.stb)};
    if (ld.mtime_hi) mtime_d = {apply_strobe(mtime_q[TIME_W-1:REG_W], wr.data, wr.stb), mtime_q[REG_W-1:0]};
    if (ld.cmp_lo)   cmp_d   = {cmp_q[TIME_W-1:REG_W], apply_strobe(cmp_q[REG_W-1:0], wr.data, wr.stb)};
    if (ld.cmp_hi)   cmp_d   = {apply_strobe(cmp_q[TIME_W-1:REG_W], wr.data, wr.stb), cmp_q[REG_W-1:0]};

    if (ld.ctrl) begin
      if (wr.stb[CTRL_EN_BIT/8]) en_d = wr.data[CTRL_EN_BIT];
      if (wr.stb[CTRL_IE_BIT/8]) ie_d = wr.data[CTRL_IE_BIT];
      for (int i = 0; i < int'(PRESCALE_WIDTH); i++) begin
        if (wr.stb[(int'(CTRL_DIV_LSB) + i) / 8]) div_d[i] = wr.data[int'(CTRL_DIV_LSB) + i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rts_n) begin
      mtime_q   <= '0;
      cmp_q     <= MTIMECMP_RST;
      div_q     <= '0;
      presc_q   <= '0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      div_q     <= div_d;
      presc_q   <= presc_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    ctrl_c = '0;
    ctrl_c[CTRL_EN_BIT] = en_q;
    ctrl_c[CTRL_IE_BIT] = ie_q;
    ctrl_c[CTRL_DIV_LSB +: PRESCALE_WIDTH] = div_q;
  end

  assign mtime    = mtime_q;
  assign mtimecmp = cmp_q;
  assign pending  = pending_q;
  assign irq      = irq_q;

endmodule

// File: rtl/apb_timer.sv
// APB slave machine timer: one-wait-state APB FSM, register decode and
// mtime_hi read shadow wrapped around timer_core.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rts_n,
  apb_timer_if.slave  apb,
  output logic        irq
);

  apb_state_e            state_q, state_d;
  logic                  pready_q, pready_d;
  logic                  perr_q, perr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [REG_W-1:0]      hi_shadow_q, hi_shadow_d;

  logic [OFFS_W-1:0]     offs_c;
  logic                  addr_err_c;
  logic [DATA_WIDTH-1:0] rd_mux_c;
  logic                  unused_addr_c;
  reg_ld_t               ld_c;
  wr_req_t               wr_c;

  logic [TIME_W-1:0]     mtime;
  logic [TIME_W-1:0]     mtimecmp;
  logic [REG_W-1:0]      ctrl_c;
  logic                  pending;

  assign offs_c        = apb.APB_paddr[4:2];
  assign addr_err_c    = (apb.APB_paddr[1:0] != 2'b00) || (offs_c > OFF_STATUS);
  assign unused_addr_c = ^apb.APB_paddr[ADDR_WIDTH-1:5];
  assign wr_c          = '{data: REG_W'(apb.APB_pdata), stb: STB_W'(apb.APB_pstb)};

  // mtime_hi reads the shadow captured by the last mtime_lo read, never the live counter.
  always_comb begin
    rd_mux_c = '0;
    case (offs_c)
      OFF_MTIME_LO: rd_mux_c = DATA_WIDTH'(mtime[REG_W-1:0]);
      OFF_MTIME_HI: rd_mux_c = DATA_WIDTH'(hi_shadow_q);
      OFF_CMP_LO:   rd_mux_c = DATA_WIDTH'(mtimecmp[REG_W-1:0]);
      OFF_CMP_HI:   rd_mux_c = DATA_WIDTH'(mtimecmp[TIME_W-1:REG_W]);
      OFF_CTRL:     rd_mux_c = DATA_WIDTH'(ctrl_c);
      OFF_STATUS:   rd_mux_c = DATA_WIDTH'(pending) << STATUS_PEND_BIT;
      default:      rd_mux_c = '0;
    endcase
  end

  // All side effects (writes, snapshot, response) happen on the WAIT -> DONE edge.
  always_comb begin
    state_d     = state_q;
    pready_d    = 1'b0;
    perr_d      = 1'b0;
    prdata_d    = '0;
    hi_shadow_d = hi_shadow_q;
    ld_c        = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (apb.APB_psel) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!apb.APB_psel) begin
          state_d = ST_IDLE;
        end else if (apb.APB_penable) begin
          state_d  = ST_DONE;
          pready_d = 1'b1;
          perr_d   = addr_err_c;
          if (!addr_err_c) begin
            if (apb.APB_pwrite) begin
              case (offs_c)
                OFF_MTIME_LO: ld_c.mtime_lo = 1'b1;
                OFF_MTIME_HI: ld_c.mtime_hi = 1'b1;
                OFF_CMP_LO:   ld_c.cmp_lo   = 1'b1;
                OFF_CMP_HI:   ld_c.cmp_hi   = 1'b1;
                OFF_CTRL:     ld_c.ctrl     = 1'b1;
                OFF_STATUS:   ld_c.clr_pend = apb.APB_pstb[STATUS_PEND_BIT/8] &
                                              apb.APB_pdata[STATUS_PEND_BIT];
                default:      ld_c = '0;
              endcase
            end else begin
              prdata_d = rd_mux_c;
              if (offs_c == OFF_MTIME_LO) hi_shadow_d = mtime[TIME_W-1:REG_W];
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rts_n) begin
      state_q     <= ST_IDLE;
      pready_q    <= 1'b0;
      perr_q      <= 1'b0;
      prdata_q    <= '0;
      hi_shadow_q <= '0;
    end else begin
      state_q     <= state_d;
      pready_q    <= pready_d;
      perr_q      <= perr_d;
      prdata_q    <= prdata_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  assign apb.APB_pready = pready_q;
  assign apb.APB_perr   = perr_q;
  assign apb.APB_prdata = prdata_q;

  timer_core #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_core (
    .clk      (clk),
    .rts_n    (rts_n),
    .ld       (ld_c),
    .wr       (wr_c),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .ctrl_c   (ctrl_c),
    .pending  (pending),
    .irq      (irq)
  );

endmodule

// File: doc/apb_timer.md
# apb_timer

APB slave machine timer sitting downstream of the CPU's APB master port, decoded by the system address decoder. Provides a 64-bit free-running `mtime` counter with prescaler, a 64-bit `mtimecmp` compare register and a level interrupt that drives the CPU `interrupt` input. Every APB access costs exactly one wait state, so the CPU's `APB_pready` stall path is exercised on every timer access.

## Interface
- `ADDR_WIDTH`, 32, APB address width; only bits [4:2] are decoded.
- `DATA_WIDTH`, 32, APB data width; fixed at 32.
- `PRESCALE_WIDTH`, 8, width of the prescaler divide field.
- `clk  in  1`: single clock.
- `rts_n  in  1`: synchronous, active-low reset, sampled on `clk` rising edge.
- `APB_paddr  in  ADDR_WIDTH`: byte address.
- `APB_pdata  in  32`: write data.
- `APB_prdata  out  32`: read data.
- `APB_psel  in  1`: slave select from decoder.
- `APB_penable  in  1`: access phase.
- `APB_pwrite  in  1`: 1 = write.
- `APB_pstb  in  4`: write byte strobes; ignored on reads.
- `APB_pready  out  1`: transfer complete.
- `APB_perr  out  1`: slave error, valid only with `APB_pready`.
- `irq  out  1`: level interrupt to CPU `interrupt`.

## Operation
- Register map (offset [4:2]):
  - 0x00 `mtime_lo`
  - 0x04 `mtime_hi`
  - 0x08 `mtimecmp_lo`
  - 0x0C `mtimecmp_hi`
  - 0x10 `ctrl`: [0] en, [1] ie, [8+:PRESCALE_WIDTH] div
  - 0x14 `status`: [0] pending, write-1-to-clear
  - 0x18/0x1C: unmapped.
- `APB_perr`=1 on unmapped offset or `APB_paddr[1:0]`≠0. Errored writes change no state. Errored reads return 0.
- Writes honour `APB_pstb` per byte.
- Prescaler:
  - When en=1, `presc` counts 0..div, then wraps to 0.
  - `mtime` increments by 1 on each wrap. div=0 means increment every cycle.
  - When en=0, `presc` and `mtime` hold.
- `mtime` is a 64-bit unsigned counter; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A read of `mtime_lo` snapshots `mtime[63:32]` into `hi_shadow`. A read of `mtime_hi` returns `hi_shadow`, never the live value.
- Compare: `mtime >= mtimecmp` (64-bit unsigned) sets pending, evaluated every cycle against the registered values.
- `irq = pending & ie`, registered output.
- Simultaneous events:
  - APB write to `mtime_lo`/`mtime_hi` in the same cycle as an increment: the write wins; that increment is lost.
  - W1C to pending in the same cycle the compare is true: set wins, pending stays 1.
  - Writing `mtimecmp` does not clear pending; software clears it via `status`.
- APB slave FSM:
  - IDLE: waiting for `APB_psel`.
  - WAIT: `APB_psel & APB_penable` first seen. `APB_pready`=0.
  - DONE: `APB_pready`=1; `APB_prdata`/`APB_perr` valid; write committed on this edge. Returns to IDLE.
  - `APB_psel` dropping in WAIT returns to IDLE; no state change, no snapshot.

## Timing
- Reset values (`rts_n`=0 at an edge):
  - `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, ctrl=0, pending=0, `presc`=0, `hi_shadow`=0.
  - `irq`=0, `APB_pready`=0, `APB_perr`=0, `APB_prdata`=0, FSM=IDLE.
- Reset mid-transfer aborts it; the master sees no `APB_pready` until a fresh access.
- Access latency: setup cycle, WAIT cycle, DONE cycle. `APB_pready` is high for exactly one cycle per transfer.
- `APB_prdata` is registered: driven in DONE, 0 otherwise.
- Written values are visible to the counter/compare logic from the cycle after DONE.
- Compare→pending: 1 cycle after `mtime` reaches `mtimecmp`. pending→`irq`: 1 further cycle.

## Structure
- Shared package `apb_timer_pkg`: register offset constants, ctrl bit positions, FSM state encoding (IDLE/WAIT/DONE), reset value of `mtimecmp`.
- One sub-module `timer_core`: prescaler, 64-bit `mtime`, compare and pending logic. Register writes enter as strobed load ports.
- APB FSM and register decode live in the top `apb_timer`.

## Test plan
- Reset defaults: hold `rts_n`=0 for 3 cycles, then read 0x10 → 0, and 0x0C → 0xFFFF_FFFF. `irq`=0. Every transfer has `APB_pready` high in exactly the 3rd cycle.
- Prescaler: write ctrl=0x0000_0301 (en, div=3), wait 40 cycles, read `mtime_lo` → 10±1. Then write ctrl=0, wait 20 cycles, re-read → unchanged.
- Atomic 64-bit read:
  - Load `mtime`=0x0000_0000_FFFF_FFFE, div=0, en=1.
  - Read lo (0xFFFF_FFFF or similar), then read hi.
  - hi must equal the value at the lo read (0), not the carried 1.
- Interrupt: set `mtimecmp`=0x20 and ie=1, en=1, div=0 from `mtime`=0. `irq` rises 2 cycles after `mtime`=0x20. W1C status while `mtime`≥`mtimecmp` → pending stays 1. Raising `mtimecmp` to 0x1000, then W1C → `irq` falls 1 cycle later.
- Errors and strobes:
  - Read 0x18 → `APB_perr`=1, `APB_prdata`=0.
  - Write 0x09 → `APB_perr`=1, `mtimecmp` unchanged.
  - Write 0x08 with pstb=4'b0010, data 0xAABB_CCDD → `mtimecmp_lo`[15:8]=0xCC, other bytes unchanged.
- Abort and write priority:
  - Drop `APB_psel` in WAIT → no `APB_pready`, no state change.
  - Assert `rts_n`=0 during WAIT → FSM IDLE, all reset values.
  - Write `mtime_lo` coincident with an increment → the written value is read back.
